// File: rtl/cv32e40x_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40x_pkg
// Purpose  : Shared constants and types for the XIF AES32 result queue.
// Revision : 1.0 - initial release
// ============================================================================
package cv32e40x_pkg;

  // AES32 instructions live in the custom-1 major opcode space
  localparam logic [6:0] c_aes32_opcode     = 7'b0101011;

  // funct5 field [29:25] selecting the AES32 flavour
  localparam logic [4:0] c_funct5_aes32esi  = 5'b10001;
  localparam logic [4:0] c_funct5_aes32esmi = 5'b10011;
  localparam logic [4:0] c_funct5_aes32dsi  = 5'b10101;
  localparam logic [4:0] c_funct5_aes32dsmi = 5'b10111;

  // Slot ID storage is sized for the widest legal XIF ID; narrower IDs are
  // zero-extended so comparisons stay full-width.
  localparam int unsigned c_slot_id_width = 32;

  typedef struct packed {
    logic [c_slot_id_width-1:0] id;
    logic [4:0]                 rd;
    logic [31:0]                data;
    logic                       committed;
    logic                       killed;
  } aes_slot_t;

endpackage
`default_nettype wire

// File: rtl/riscv_crypto_fu_saes32.sv
`default_nettype none
// ============================================================================
// Module   : riscv_crypto_fu_saes32
// Purpose  : Combinational AES32 single-byte round step (encrypt/decrypt,
//            with or without MixColumns) as used by the Zkne/Zknd AES32 ops.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_crypto_fu_saes32 #(
  parameter int SAES_DEC_EN = 1
) (
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [1:0]  bs,
  input  logic        op_saes32_encs,
  input  logic        op_saes32_encsm,
  input  logic        op_saes32_decs,
  input  logic        op_saes32_decsm,
  output logic [31:0] rd,
  output logic        ready
);

  // Multiply by x in GF(2^8) modulo the AES polynomial
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = gf_xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), a);
    end
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
             ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  logic [7:0]  w_byte;
  logic [7:0]  w_sbox_fwd;
  logic [7:0]  w_sbox_inv;
  logic [7:0]  w_x;
  logic [31:0] w_mix;
  logic [31:0] w_rot;
  logic        w_enc;
  logic        w_dec;

  assign w_enc      = op_saes32_encs | op_saes32_encsm;
  assign w_dec      = op_saes32_decs | op_saes32_decsm;
  assign w_sbox_fwd = aff_fwd(gf_inv(w_byte));

  if (SAES_DEC_EN != 0) begin : g_dec
    assign w_sbox_inv = gf_inv(aff_inv(w_byte));
  end else begin : g_no_dec
    assign w_sbox_inv = 8'h00;
  end

  assign w_x = w_enc ? w_sbox_fwd : (w_dec ? w_sbox_inv : 8'h00);

  // Pick the rs2 byte addressed by bs
  always_comb begin
    case (bs)
      2'd0:    w_byte = rs2[7:0];
      2'd1:    w_byte = rs2[15:8];
      2'd2:    w_byte = rs2[23:16];
      default: w_byte = rs2[31:24];
    endcase
  end

  // Expand the substituted byte into a column, with optional MixColumns
  always_comb begin
    w_mix = {24'h000000, w_x};
    if (op_saes32_encsm) begin
      w_mix = {gf_mul(w_x, 8'h03), w_x, w_x, gf_mul(w_x, 8'h02)};
    end else if (op_saes32_decsm) begin
      w_mix = {gf_mul(w_x, 8'h0b), gf_mul(w_x, 8'h0d),
               gf_mul(w_x, 8'h09), gf_mul(w_x, 8'h0e)};
    end
  end

  // Rotate the column back into the byte lane it came from
  always_comb begin
    case (bs)
      2'd0:    w_rot = w_mix;
      2'd1:    w_rot = {w_mix[23:0], w_mix[31:24]};
      2'd2:    w_rot = {w_mix[15:0], w_mix[31:16]};
      default: w_rot = {w_mix[7:0],  w_mix[31:8]};
    endcase
  end

  assign rd    = valid ? (rs1 ^ w_rot) : 32'h0000_0000;
  assign ready = valid;

endmodule
`default_nettype wire

// File: rtl/cv32e40x_xif_aes_queue.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40x_xif_aes_queue
// Purpose  : XIF coprocessor for AES32 ops. Results are computed at issue
//            and held in an in-order queue until commit; killed entries are
//            dropped silently, committed ones are returned in order.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40x_xif_aes_queue
  import cv32e40x_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFR_WIDTH = 32,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [31:0]              issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]    issue_id_i,
  input  logic [2*X_RFR_WIDTH-1:0] issue_rs_i,
  input  logic [1:0]               issue_rs_valid_i,
  output logic                     issue_accept_o,
  output logic                     issue_writeback_o,
  input  logic                     commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]    commit_id_i,
  input  logic                     commit_kill_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [X_ID_WIDTH-1:0]    result_id_o,
  output logic [X_RFR_WIDTH-1:0]   result_data_o,
  output logic [4:0]               result_rd_o,
  output logic                     result_we_o
);

  localparam int unsigned      PTR_W       = $clog2(DEPTH);
  localparam logic [PTR_W:0]   c_depth     = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   c_ptr_one   = (PTR_W+1)'(1);

  aes_slot_t                   r_slots [DEPTH];
  logic [PTR_W:0]              r_head;
  logic [PTR_W:0]              r_tail;

  logic [PTR_W:0]              w_count;
  logic [DEPTH-1:0]            w_occupied;
  logic [6:0]                  w_opcode;
  logic [4:0]                  w_funct5;
  logic                        w_op_esi, w_op_esmi, w_op_dsi, w_op_dsmi;
  logic                        w_is_aes;
  logic                        w_accept;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_present;
  logic                        w_drop;
  logic [31:0]                 w_aes_result;
  logic                        w_aes_ready;
  logic [c_slot_id_width-1:0]  w_issue_id_ext;
  logic [c_slot_id_width-1:0]  w_commit_id_ext;
  logic                        w_commit_new;
  aes_slot_t                   w_new_slot;
  aes_slot_t                   w_head_slot;
  logic                        w_unused_instr;

  // ---------------------------------------------------------------- decode
  assign w_opcode  = issue_instr_i[6:0];
  assign w_funct5  = issue_instr_i[29:25];
  assign w_op_esi  = (w_opcode == c_aes32_opcode) && (w_funct5 == c_funct5_aes32esi);
  assign w_op_esmi = (w_opcode == c_aes32_opcode) && (w_funct5 == c_funct5_aes32esmi);
  assign w_op_dsi  = (w_opcode == c_aes32_opcode) && (w_funct5 == c_funct5_aes32dsi);
  assign w_op_dsmi = (w_opcode == c_aes32_opcode) && (w_funct5 == c_funct5_aes32dsmi);
  assign w_is_aes  = w_op_esi | w_op_esmi | w_op_dsi | w_op_dsmi;

  // Register-index and funct3 fields carry no information for this unit
  assign w_unused_instr = ^issue_instr_i[24:12];

  // ------------------------------------------------------------- occupancy
  assign w_count       = r_tail - r_head;
  // Ready looks only at registered occupancy, so a pop this cycle never frees a slot early
  assign issue_ready_o = (w_count < c_depth);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
    logic [PTR_W-1:0] w_off;
    assign w_off          = PTR_W'(gi) - r_head[PTR_W-1:0];
    assign w_occupied[gi] = ({1'b0, w_off} < w_count);
  end

  // Gate with rst_n so the handshake outputs are quiet while reset is held
  assign w_accept          = rst_n & issue_valid_i & issue_ready_o & w_is_aes
                             & (&issue_rs_valid_i);
  assign issue_accept_o    = w_accept;
  assign issue_writeback_o = w_accept;

  // ------------------------------------------------------- AES computation
  riscv_crypto_fu_saes32 #(
    .SAES_DEC_EN (1)
  ) u_saes32 (
    .valid           (w_accept),
    .rs1             (issue_rs_i[X_RFR_WIDTH-1:0]),
    .rs2             (issue_rs_i[2*X_RFR_WIDTH-1:X_RFR_WIDTH]),
    .bs              (issue_instr_i[31:30]),
    .op_saes32_encs  (w_op_esi),
    .op_saes32_encsm (w_op_esmi),
    .op_saes32_decs  (w_op_dsi),
    .op_saes32_decsm (w_op_dsmi),
    .rd              (w_aes_result),
    .ready           (w_aes_ready)
  );

  assign w_push = w_accept & w_aes_ready;

  // Zero-extend IDs to the slot ID width and build the entry being enqueued
  always_comb begin
    w_issue_id_ext                    = '0;
    w_issue_id_ext[X_ID_WIDTH-1:0]    = issue_id_i;
    w_commit_id_ext                   = '0;
    w_commit_id_ext[X_ID_WIDTH-1:0]   = commit_id_i;
    // A commit arriving with its own issue is folded straight into the new slot
    w_commit_new                      = commit_valid_i && (commit_id_i == issue_id_i);
    w_new_slot                        = '0;
    w_new_slot.id                     = w_issue_id_ext;
    w_new_slot.rd                     = issue_instr_i[11:7];
    w_new_slot.data                   = w_aes_result;
    w_new_slot.committed              = w_commit_new;
    w_new_slot.killed                 = w_commit_new & commit_kill_i;
  end

  // ---------------------------------------------------------- head / result
  assign w_head_slot    = r_slots[r_head[PTR_W-1:0]];
  assign w_present      = (w_count != '0) && w_head_slot.committed && !w_head_slot.killed;
  assign w_drop         = (w_count != '0) && w_head_slot.committed &&  w_head_slot.killed;
  assign w_pop          = (w_present && result_ready_i) || w_drop;

  assign result_valid_o = w_present;
  assign result_we_o    = w_present;
  assign result_id_o    = w_head_slot.id[X_ID_WIDTH-1:0];
  assign result_data_o  = w_head_slot.data;
  assign result_rd_o    = w_head_slot.rd;

  // Slot storage, commit marking and pointer movement
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_slots[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_valid_i && w_occupied[i] && (r_slots[i].id == w_commit_id_ext)) begin
          r_slots[i].committed <= 1'b1;
          if (commit_kill_i) r_slots[i].killed <= 1'b1;
        end
      end
      // The tail slot is never occupied, so it cannot collide with a commit update
      if (w_push) begin
        r_slots[r_tail[PTR_W-1:0]] <= w_new_slot;
        r_tail                     <= r_tail + c_ptr_one;
      end
      if (w_pop) begin
        r_head <= r_head + c_ptr_one;
      end
    end
  end

endmodule
`default_nettype wire
